// File: rtl/tl_mtimer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tl_mtimer_pkg
// Desc     : Register map and control-register layout of the machine timer.
// Revision : 1.0 - initial release
// ============================================================================
package tl_mtimer_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int PRESC_W_MAX = 16;

    localparam logic [REG_ADDR_W-1:0] MTIME_LO_OFFSET    = 5'h00;
    localparam logic [REG_ADDR_W-1:0] MTIME_HI_OFFSET    = 5'h04;
    localparam logic [REG_ADDR_W-1:0] MTIMECMP_LO_OFFSET = 5'h08;
    localparam logic [REG_ADDR_W-1:0] MTIMECMP_HI_OFFSET = 5'h0C;
    localparam logic [REG_ADDR_W-1:0] CTRL_OFFSET        = 5'h10;
    localparam logic [REG_ADDR_W-1:0] STATUS_OFFSET      = 5'h14;

    typedef struct packed {
        logic [PRESC_W_MAX-1:0] presc;
        logic                   en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tlul_pkg
// Desc     : Minimal TileLink-UL channel types and opcodes for 32-bit devices.
// Revision : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] TL_GET              = 3'h4;
    localparam logic [2:0] TL_ACCESS_ACK       = 3'h0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/tl_mtimer_core.sv
`default_nettype none
// ============================================================================
// Module   : tl_mtimer_core
// Desc     : Prescaled 64-bit mtime counter, mtimecmp and registered interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module tl_mtimer_core
    import tl_mtimer_pkg::*;
#(
    parameter int PRESC_W   = 16,
    parameter int RST_PRESC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]           i_wr_data,
    output ctrl_t                 o_ctrl,
    output logic [63:0]           o_mtime,
    output logic [63:0]           o_mtimecmp,
    output logic                  o_irq,
    output logic                  o_tick
);

    ctrl_t              r_ctrl;
    logic [PRESC_W-1:0] r_pcnt;
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_irq;

    logic w_tick;
    logic w_we_mtime_lo;
    logic w_we_mtime_hi;
    logic w_we_cmp_lo;
    logic w_we_cmp_hi;
    logic w_we_ctrl;

    assign w_tick        = r_ctrl.en && (r_pcnt == r_ctrl.presc[PRESC_W-1:0]);
    assign w_we_mtime_lo = i_wr_en && (i_wr_addr == MTIME_LO_OFFSET);
    assign w_we_mtime_hi = i_wr_en && (i_wr_addr == MTIME_HI_OFFSET);
    assign w_we_cmp_lo   = i_wr_en && (i_wr_addr == MTIMECMP_LO_OFFSET);
    assign w_we_cmp_hi   = i_wr_en && (i_wr_addr == MTIMECMP_HI_OFFSET);
    assign w_we_ctrl     = i_wr_en && (i_wr_addr == CTRL_OFFSET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl.en    <= 1'b0;
            r_ctrl.presc <= PRESC_W_MAX'(RST_PRESC);
            r_pcnt       <= '0;
            r_mtime      <= '0;
            r_mtimecmp   <= '1;
            r_irq        <= 1'b0;
        end else begin
            if (w_we_ctrl) begin
                r_ctrl.en    <= i_wr_data[0];
                r_ctrl.presc <= PRESC_W_MAX'(i_wr_data[PRESC_W+15:16]);
                r_pcnt       <= '0;
            end else if (w_tick) begin
                r_pcnt <= '0;
            end else if (r_ctrl.en) begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            // A software write to either half replaces the count; a coincident tick is lost.
            if (w_we_mtime_lo) begin
                r_mtime[31:0] <= i_wr_data;
            end else if (w_we_mtime_hi) begin
                r_mtime[63:32] <= i_wr_data;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_we_cmp_lo) begin
                r_mtimecmp[31:0] <= i_wr_data;
            end
            if (w_we_cmp_hi) begin
                r_mtimecmp[63:32] <= i_wr_data;
            end

            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_ctrl     = r_ctrl;
    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_irq      = r_irq;
    assign o_tick     = w_tick;

endmodule
`default_nettype wire

// File: rtl/tl_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : tl_mtimer
// Desc     : TL-UL RISC-V machine timer: register decode, response and errors.
// Revision : 1.0 - initial release
// ============================================================================
module tl_mtimer
    import tl_mtimer_pkg::*;
#(
    parameter int PRESC_W   = 16,
    parameter int RST_PRESC = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              timer_irq_o,
    output logic              tick_o
);

    ctrl_t                 w_ctrl;
    logic [63:0]           w_mtime;
    logic [63:0]           w_mtimecmp;
    logic                  w_irq;
    logic [REG_ADDR_W-1:0] w_addr;
    logic                  w_is_get;
    logic                  w_is_put;
    logic                  w_err;
    logic                  w_a_ready;
    logic                  w_accept;
    logic                  w_wr_en;
    logic [31:0]           w_ctrl_word;
    logic [31:0]           w_rdata;
    logic [31:0]           w_wdata;
    logic                  w_unused;

    logic                  r_d_valid;
    logic [2:0]            r_d_opcode;
    logic [1:0]            r_d_size;
    logic [7:0]            r_d_source;
    logic [31:0]           r_d_data;
    logic                  r_d_error;

    assign w_addr    = tl_i.a_address[REG_ADDR_W-1:0];
    assign w_is_get  = (tl_i.a_opcode == tlul_pkg::TL_GET);
    assign w_is_put  = (tl_i.a_opcode == tlul_pkg::TL_PUT_FULL_DATA) ||
                       (tl_i.a_opcode == tlul_pkg::TL_PUT_PARTIAL_DATA);
    assign w_err     = !(w_is_get || w_is_put) || (tl_i.a_size != 2'd2) ||
                       (tl_i.a_address[1:0] != 2'b00) || (w_addr > STATUS_OFFSET);
    assign w_a_ready = !r_d_valid || tl_i.d_ready;
    assign w_accept  = tl_i.a_valid && w_a_ready;
    assign w_wr_en   = w_accept && w_is_put && !w_err;
    assign w_unused  = ^{tl_i.a_param, tl_i.a_address[31:REG_ADDR_W]};

    always_comb begin
        w_ctrl_word                 = '0;
        w_ctrl_word[0]              = w_ctrl.en;
        w_ctrl_word[PRESC_W+15:16]  = w_ctrl.presc[PRESC_W-1:0];
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            MTIME_LO_OFFSET:    w_rdata = w_mtime[31:0];
            MTIME_HI_OFFSET:    w_rdata = w_mtime[63:32];
            MTIMECMP_LO_OFFSET: w_rdata = w_mtimecmp[31:0];
            MTIMECMP_HI_OFFSET: w_rdata = w_mtimecmp[63:32];
            CTRL_OFFSET:        w_rdata = w_ctrl_word;
            STATUS_OFFSET:      w_rdata = {31'b0, w_irq};
            default:            w_rdata = '0;
        endcase
    end

    // Byte-masked merge onto the current contents covers both Put flavours.
    always_comb begin
        w_wdata = w_rdata;
        for (int b = 0; b < 4; b++) begin
            if (tl_i.a_mask[b]) begin
                w_wdata[8*b +: 8] = tl_i.a_data[8*b +: 8];
            end
        end
    end

    tl_mtimer_core #(
        .PRESC_W   (PRESC_W),
        .RST_PRESC (RST_PRESC)
    ) u_core (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_addr),
        .i_wr_data  (w_wdata),
        .o_ctrl     (w_ctrl),
        .o_mtime    (w_mtime),
        .o_mtimecmp (w_mtimecmp),
        .o_irq      (w_irq),
        .o_tick     (tick_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
            r_d_error  <= 1'b0;
        end else if (w_accept) begin
            r_d_valid  <= 1'b1;
            r_d_opcode <= w_is_get ? tlul_pkg::TL_ACCESS_ACK_DATA : tlul_pkg::TL_ACCESS_ACK;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_data   <= (w_is_get && !w_err) ? w_rdata : 32'h0;
            r_d_error  <= w_err;
        end else if (tl_i.d_ready) begin
            r_d_valid  <= 1'b0;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = r_d_valid;
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_data   = r_d_data;
        tl_o.d_error  = r_d_error;
        tl_o.a_ready  = w_a_ready;
    end

    assign timer_irq_o = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_tl_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_mtimer
// Desc     : Self-checking bench for tl_mtimer against a time-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_mtimer;
    import tlul_pkg::*;
    import tl_mtimer_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    tl_h2d_t h2d;
    tl_d2h_t d2h;
    logic    irq;
    logic    tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] mdl_cmp;
    logic [31:0] mdl_ctrl;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_mtimer u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tl_i        (h2d),
        .tl_o        (d2h),
        .timer_irq_o (irq),
        .tick_o      (tick)
    );

    // Enabled for `edges` clocks, the counter advances once every presc+1 clocks.
    function automatic logic [63:0] mt_after(input logic [63:0] start, input int presc, input int edges);
        return start + 64'(edges / (presc + 1));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic tl_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [1:0] size,
                          output logic [31:0] rdata, output logic rerr, output logic [2:0] rop,
                          output int acc);
        logic [7:0] src;
        src = 8'($urandom_range(0, 255));
        @(negedge clk);
        h2d.a_valid   = 1'b1;
        h2d.a_opcode  = op;
        h2d.a_param   = 3'b0;
        h2d.a_size    = size;
        h2d.a_source  = src;
        h2d.a_address = addr;
        h2d.a_mask    = mask;
        h2d.a_data    = wdata;
        h2d.d_ready   = 1'b1;
        @(posedge clk);
        acc = cyc;
        @(negedge clk);
        h2d.a_valid = 1'b0;
        rdata = d2h.d_data;
        rerr  = d2h.d_error;
        rop   = d2h.d_opcode;
        checks++;
        if (d2h.d_valid !== 1'b1 || d2h.d_source !== src || d2h.d_size !== size) begin
            errors++;
            $display("FAIL response: d_valid=%b d_source=%h d_size=%0d, required 1 %h %0d",
                     d2h.d_valid, d2h.d_source, d2h.d_size, src, size);
        end
    endtask

    task automatic reg_wr(input logic [4:0] off, input logic [31:0] data, output int acc);
        logic [31:0] d; logic e; logic [2:0] o;
        tl_req(TL_PUT_FULL_DATA, {27'h0, off}, data, 4'hF, 2'd2, d, e, o, acc);
    endtask

    task automatic reg_rd(input logic [4:0] off, output logic [31:0] data);
        logic e; logic [2:0] o; int acc;
        tl_req(TL_GET, {27'h0, off}, 32'h0, 4'hF, 2'd2, data, e, o, acc);
    endtask

    task automatic test_reset;
        logic [31:0] d; logic e; logic [2:0] o; int acc;
        h2d = '0;
        h2d.d_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (d2h.d_valid !== 1'b0 || d2h.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: d_valid=%b a_ready=%b, required 0 1", d2h.d_valid, d2h.a_ready);
        end
        checks++;
        if (irq !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b tick=%b, required 0 0", irq, tick);
        end
        rst = 1'b0;
        mdl_cmp  = '1;
        mdl_ctrl = 32'h0;
        tl_req(TL_GET, 32'h10, 32'h0, 4'hF, 2'd2, d, e, o, acc);
        checks++;
        if (d !== 32'h0 || e !== 1'b0 || o !== TL_ACCESS_ACK_DATA) begin
            errors++;
            $display("FAIL reset_ctrl: data=%h err=%b op=%0d, required 0 0 %0d", d, e, o, TL_ACCESS_ACK_DATA);
        end
        tl_req(TL_GET, 32'h0C, 32'h0, 4'hF, 2'd2, d, e, o, acc);
        checks++;
        if (d !== 32'hFFFF_FFFF || e !== 1'b0 || o !== TL_ACCESS_ACK_DATA) begin
            errors++;
            $display("FAIL reset_cmp_hi: data=%h err=%b op=%0d, required ffffffff 0 %0d", d, e, o, TL_ACCESS_ACK_DATA);
        end
        reg_rd(5'h00, d);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mtime: mtime_lo=%h irq=%b, required 0 0", d, irq);
        end
    endtask

    task automatic test_prescaler;
        int acc_en, acc_dis, e;
        logic [31:0] d;
        logic [63:0] expv;
        reg_wr(5'h10, {16'd3, 15'b0, 1'b1}, acc_en);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            e = cyc - acc_en - 1;
            checks++;
            if (tick !== ((e % 4) == 3)) begin
                errors++;
                $display("FAIL tick_period: clock %0d after enable tick=%b, required %b", e, tick, (e % 4) == 3);
            end
        end
        reg_wr(5'h10, 32'h0, acc_dis);
        expv = mt_after(64'h0, 3, acc_dis - acc_en);
        reg_rd(5'h00, d);
        checks++;
        if (d !== expv[31:0]) begin
            errors++;
            $display("FAIL presc_count: mtime_lo=%0d, required %0d", d, expv[31:0]);
        end
        checks++;
        if (d < 32'd9 || d > 32'd11) begin
            errors++;
            $display("FAIL presc_range: mtime_lo=%0d, required 10 +/- 1", d);
        end
    endtask

    task automatic test_wrap;
        int acc, acc_en, acc_dis;
        logic [31:0] d;
        logic [63:0] start, fin;
        start = 64'hFFFF_FFFF_FFFF_FFFE;
        reg_wr(5'h00, start[31:0], acc);
        reg_wr(5'h04, start[63:32], acc);
        reg_wr(5'h08, 32'hFFFF_FFFF, acc);
        reg_wr(5'h0C, 32'hFFFF_FFFF, acc);
        mdl_cmp = '1;
        reg_wr(5'h10, 32'h1, acc_en);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq_before: irq=%b, required 0", irq);
        end
        reg_wr(5'h10, 32'h0, acc_dis);
        checks++;
        if (irq !== ((start + 64'(acc_dis - acc_en - 1)) >= mdl_cmp)) begin
            errors++;
            $display("FAIL wrap_irq_at_max: irq=%b, required %b", irq, (start + 64'(acc_dis - acc_en - 1)) >= mdl_cmp);
        end
        fin = mt_after(start, 0, acc_dis - acc_en);
        @(negedge clk);
        checks++;
        if (irq !== (fin >= mdl_cmp)) begin
            errors++;
            $display("FAIL wrap_irq_after: irq=%b, required %b", irq, fin >= mdl_cmp);
        end
        reg_rd(5'h00, d);
        checks++;
        if (d !== fin[31:0]) begin
            errors++;
            $display("FAIL wrap_lo: got %h, required %h", d, fin[31:0]);
        end
        reg_rd(5'h04, d);
        checks++;
        if (d !== fin[63:32]) begin
            errors++;
            $display("FAIL wrap_hi: got %h, required %h", d, fin[63:32]);
        end
    endtask

    task automatic test_irq;
        int acc, acc_en, acc_dis, e;
        logic [31:0] d;
        logic [63:0] fin;
        reg_wr(5'h00, 32'h0, acc);
        reg_wr(5'h04, 32'h0, acc);
        reg_wr(5'h08, 32'd5, acc);
        reg_wr(5'h0C, 32'h0, acc);
        mdl_cmp = 64'd5;
        reg_wr(5'h10, 32'h1, acc_en);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            e = cyc - acc_en - 1;
            checks++;
            if (irq !== (e >= 1 && (e - 1) >= 5)) begin
                errors++;
                $display("FAIL irq_rise: clock %0d irq=%b, required %b", e, irq, (e >= 1 && (e - 1) >= 5));
            end
        end
        reg_wr(5'h08, 32'd100, acc);
        mdl_cmp = 64'd100;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold: irq=%b, required 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop: irq=%b, required 0", irq);
        end
        reg_wr(5'h10, 32'h0, acc_dis);
        fin = mt_after(64'h0, 0, acc_dis - acc_en);
        reg_rd(5'h00, d);
        checks++;
        if (d !== fin[31:0]) begin
            errors++;
            $display("FAIL irq_count: mtime_lo=%0d, required %0d", d, fin[31:0]);
        end
    endtask

    task automatic test_random;
        int acc, acc_en, acc_dis, presc, wt;
        logic [63:0] start, fin;
        logic [31:0] d, a, b, rd;
        logic [3:0]  m;
        logic        e;
        logic [2:0]  o;
        for (int it = 0; it < 4; it++) begin
            start = {$urandom, $urandom};
            presc = $urandom_range(0, 7);
            wt    = $urandom_range(3, 30);
            reg_wr(5'h00, start[31:0], acc);
            reg_wr(5'h04, start[63:32], acc);
            reg_wr(5'h10, {16'(presc), 15'b0, 1'b1}, acc_en);
            repeat (wt) @(negedge clk);
            reg_wr(5'h10, {16'(presc), 16'b0}, acc_dis);
            mdl_ctrl = {16'(presc), 16'b0};
            fin = mt_after(start, presc, acc_dis - acc_en);
            reg_rd(5'h00, d);
            reg_rd(5'h04, rd);
            checks++;
            if ({rd, d} !== fin) begin
                errors++;
                $display("FAIL rand_mtime: presc=%0d got %h, required %h", presc, {rd, d}, fin);
            end
            reg_rd(5'h10, d);
            checks++;
            if (d !== mdl_ctrl) begin
                errors++;
                $display("FAIL rand_ctrl: got %h, required %h", d, mdl_ctrl);
            end
            a = $urandom;
            b = $urandom;
            m = 4'($urandom_range(0, 15));
            reg_wr(5'h08, a, acc);
            tl_req(TL_PUT_PARTIAL_DATA, 32'h08, b, m, 2'd2, d, e, o, acc);
            checks++;
            if (o !== TL_ACCESS_ACK || e !== 1'b0) begin
                errors++;
                $display("FAIL partial_ack: op=%0d err=%b, required %0d 0", o, e, TL_ACCESS_ACK);
            end
            mdl_cmp[31:0] = merge(a, b, m);
            reg_rd(5'h08, d);
            checks++;
            if (d !== mdl_cmp[31:0]) begin
                errors++;
                $display("FAIL partial_merge: mask=%h got %h, required %h", m, d, mdl_cmp[31:0]);
            end
        end
    endtask

    task automatic test_errors;
        logic [2:0]  ops   [6];
        logic [31:0] addrs [6];
        logic [1:0]  sizes [6];
        logic [31:0] d;
        logic        e;
        logic [2:0]  o;
        int          acc;
        ops[0] = TL_GET;           addrs[0] = 32'h00; sizes[0] = 2'd1;
        ops[1] = TL_GET;           addrs[1] = 32'h18; sizes[1] = 2'd2;
        ops[2] = TL_GET;           addrs[2] = 32'h02; sizes[2] = 2'd2;
        ops[3] = TL_PUT_FULL_DATA; addrs[3] = 32'h08; sizes[3] = 2'd1;
        ops[4] = 3'h2;             addrs[4] = 32'h08; sizes[4] = 2'd2;
        ops[5] = TL_PUT_FULL_DATA; addrs[5] = 32'h0A; sizes[5] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tl_req(ops[i], addrs[i], 32'hDEAD_BEEF, 4'hF, sizes[i], d, e, o, acc);
            checks++;
            if (e !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL bad_access_%0d: err=%b data=%h, required 1 0", i, e, d);
            end
        end
        reg_rd(5'h08, d);
        checks++;
        if (d !== mdl_cmp[31:0]) begin
            errors++;
            $display("FAIL bad_access_nochange: cmp_lo=%h, required %h", d, mdl_cmp[31:0]);
        end
        tl_req(TL_PUT_FULL_DATA, 32'h14, 32'hFFFF_FFFF, 4'hF, 2'd2, d, e, o, acc);
        checks++;
        if (e !== 1'b0 || o !== TL_ACCESS_ACK) begin
            errors++;
            $display("FAIL status_write: err=%b op=%0d, required 0 %0d", e, o, TL_ACCESS_ACK);
        end
        reg_rd(5'h10, d);
        checks++;
        if (d !== mdl_ctrl) begin
            errors++;
            $display("FAIL status_write_nochange: ctrl=%h, required %h", d, mdl_ctrl);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        h2d.d_ready   = 1'b0;
        h2d.a_valid   = 1'b1;
        h2d.a_opcode  = TL_GET;
        h2d.a_size    = 2'd2;
        h2d.a_mask    = 4'hF;
        h2d.a_source  = 8'h11;
        h2d.a_address = 32'h08;
        @(negedge clk);
        h2d.a_source  = 8'h22;
        h2d.a_address = 32'h10;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d2h.a_ready !== 1'b0 || d2h.d_valid !== 1'b1 || d2h.d_source !== 8'h11 ||
                d2h.d_data !== mdl_cmp[31:0]) begin
                errors++;
                $display("FAIL b2b_stall_%0d: a_ready=%b d_valid=%b src=%h data=%h, required 0 1 11 %h",
                         i, d2h.a_ready, d2h.d_valid, d2h.d_source, d2h.d_data, mdl_cmp[31:0]);
            end
            @(negedge clk);
        end
        h2d.d_ready = 1'b1;
        @(negedge clk);
        h2d.a_valid = 1'b0;
        checks++;
        if (d2h.d_valid !== 1'b1 || d2h.d_source !== 8'h22 || d2h.d_data !== mdl_ctrl) begin
            errors++;
            $display("FAIL b2b_second: d_valid=%b src=%h data=%h, required 1 22 %h",
                     d2h.d_valid, d2h.d_source, d2h.d_data, mdl_ctrl);
        end
        @(negedge clk);
        checks++;
        if (d2h.d_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: d_valid=%b, required 0", d2h.d_valid);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d;
        @(negedge clk);
        h2d.d_ready   = 1'b0;
        h2d.a_valid   = 1'b1;
        h2d.a_opcode  = TL_GET;
        h2d.a_address = 32'h00;
        @(negedge clk);
        h2d.a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (d2h.d_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: d_valid=%b, required 0", d2h.d_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        h2d.d_ready = 1'b1;
        reg_rd(5'h0C, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL midflight_cmp_hi: got %h, required ffffffff", d);
        end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_wrap();
        test_irq();
        test_random();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
